// File: rtl/data_ram.sv
// rtl/data_ram.sv - dual-port byte-writable 32-bit data RAM, read-first, port B wins collisions
module data_ram #(
    parameter int ADDR_LEN = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  wea,
    input  logic [29:0] addra,
    input  logic [31:0] dina,
    output logic [31:0] douta,
    input  logic [3:0]  web,
    input  logic [29:0] addrb,
    input  logic [31:0] dinb,
    output logic [31:0] doutb
);

    localparam int DEPTH = 1 << ADDR_LEN;

    logic [31:0] mem_q [DEPTH] = '{default: 32'h0};
    logic [31:0] douta_q;
    logic [31:0] doutb_q;
    logic [31:0] douta_d;
    logic [31:0] doutb_d;

    logic [ADDR_LEN-1:0] idx_a;
    logic [ADDR_LEN-1:0] idx_b;

    // Upper address bits are deliberately ignored so the array aliases.
    assign idx_a = addra[ADDR_LEN-1:0];
    assign idx_b = addrb[ADDR_LEN-1:0];

    generate
        if (ADDR_LEN < 30) begin : g_unused_addr
            logic unused_addr;
            assign unused_addr = ^{addra[29:ADDR_LEN], addrb[29:ADDR_LEN]};
        end
    endgenerate

    always_comb begin
        douta_d = mem_q[idx_a];
        doutb_d = mem_q[idx_b];
        if (rst) begin
            douta_d = 32'h0;
            doutb_d = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        douta_q <= douta_d;
        doutb_q <= doutb_d;
    end

    // Port B lanes are written after port A so B takes the byte on a collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (wea[i]) begin
                    mem_q[idx_a][8*i +: 8] <= dina[8*i +: 8];
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (web[i]) begin
                    mem_q[idx_b][8*i +: 8] <= dinb[8*i +: 8];
                end
            end
        end
    end

    assign douta = douta_q;
    assign doutb = doutb_q;

endmodule

// File: tb/tb_data_ram.sv
// tb/tb_data_ram.sv - directed self-checking bench for data_ram
module tb_data_ram;

    logic        clk;
    logic        rst;
    logic [3:0]  wea;
    logic [29:0] addra;
    logic [31:0] dina;
    logic [31:0] douta;
    logic [3:0]  web;
    logic [29:0] addrb;
    logic [31:0] dinb;
    logic [31:0] doutb;

    int checks;
    int failures;

    data_ram #(.ADDR_LEN(12)) dut (
        .clk   (clk),
        .rst   (rst),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .douta (douta),
        .web   (web),
        .addrb (addrb),
        .dinb  (dinb),
        .doutb (doutb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic [3:0] we, input logic [29:0] ad, input logic [31:0] d);
        wea = we; addra = ad; dina = d;
    endtask

    task automatic set_b(input logic [3:0] we, input logic [29:0] ad, input logic [31:0] d);
        web = we; addrb = ad; dinb = d;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        set_a(4'h0, 30'h0, 32'h0);
        set_b(4'h0, 30'h0, 32'h0);
        cyc();
        check("reset_douta", douta, 32'h0);
        check("reset_doutb", doutb, 32'h0);
        rst = 1'b0;

        // full-word write then read
        set_a(4'hF, 30'd5, 32'hDEADBEEF);
        cyc();
        check("wr5_readfirst", douta, 32'h0);
        set_a(4'h0, 30'd5, 32'h0);
        cyc();
        check("rd5_full", douta, 32'hDEADBEEF);

        // byte mask
        set_a(4'b0101, 30'd5, 32'h11223344);
        cyc();
        set_a(4'h0, 30'd5, 32'h0);
        cyc();
        check("rd5_mask", douta, 32'hDE22BE44);

        // read-first on port A
        set_a(4'hF, 30'd7, 32'hAAAAAAAA);
        cyc();
        set_a(4'hF, 30'd7, 32'h55555555);
        cyc();
        check("rd7_old", douta, 32'hAAAAAAAA);
        set_a(4'h0, 30'd7, 32'h0);
        cyc();
        check("rd7_new", douta, 32'h55555555);

        // dual-port collision, B wins overlapping byte
        set_a(4'b0011, 30'd9, 32'h11111111);
        set_b(4'b0110, 30'd9, 32'h22222222);
        cyc();
        check("coll_douta_old", douta, 32'h0);
        check("coll_doutb_old", doutb, 32'h0);
        set_a(4'h0, 30'd9, 32'h0);
        set_b(4'h0, 30'd9, 32'h0);
        cyc();
        check("coll_doutb", doutb, 32'h00222211);
        check("coll_douta", douta, 32'h00222211);

        // aliasing of upper address bits
        set_a(4'hF, 30'h1003, 32'h12345678);
        set_b(4'h0, 30'd3, 32'h0);
        cyc();
        check("alias_b_old", doutb, 32'h0);
        set_a(4'h0, 30'h3FFFF003, 32'h0);
        cyc();
        check("alias_b", doutb, 32'h12345678);
        check("alias_a_hi", douta, 32'h12345678);

        // cross-port read of a word being written returns old data
        set_a(4'h0, 30'd3, 32'h0);
        set_b(4'b1000, 30'd3, 32'h9A000000);
        cyc();
        check("cross_old", douta, 32'h12345678);
        set_b(4'h0, 30'd3, 32'h0);
        cyc();
        check("cross_new", douta, 32'h9A345678);

        // reset suppresses writes and clears outputs only
        set_a(4'hF, 30'd4, 32'hCAFEF00D);
        cyc();
        set_a(4'h0, 30'd4, 32'h0);
        set_b(4'h0, 30'd4, 32'h0);
        cyc();
        check("pre_rst_douta", douta, 32'hCAFEF00D);
        rst = 1'b1;
        set_a(4'hF, 30'd4, 32'h0);
        set_b(4'hF, 30'd4, 32'h0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("rst_douta", douta, 32'h0);
            check("rst_doutb", doutb, 32'h0);
        end
        rst = 1'b0;
        set_a(4'h0, 30'd4, 32'h0);
        set_b(4'h0, 30'd4, 32'h0);
        cyc();
        check("post_rst_douta", douta, 32'hCAFEF00D);
        check("post_rst_doutb", doutb, 32'hCAFEF00D);

        // first edge after reset writes immediately
        set_a(4'b0001, 30'd4, 32'h000000EE);
        cyc();
        set_a(4'h0, 30'd4, 32'h0);
        cyc();
        check("post_rst_write", douta, 32'hCAFEF0EE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 Parameter ADDR_LEN, default 12, meaning word-address bits actually decoded; depth = 2^ADDR_LEN 32-bit words.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; one clock, synchronous, active-high.
REQ-004 wea  input  4  port A byte write enables; bit i enables byte i (bits 8i+7:8i).
REQ-005 addra  input  30  port A word address.
REQ-006 dina  input  32  port A write data.
REQ-007 douta  output  32  port A registered read data.
REQ-008 web  input  4  port B (debug) byte write enables, same mapping as wea.
REQ-009 addrb  input  30  port B word address.
REQ-010 dinb  input  32  port B write data.
REQ-011 doutb  output  32  port B registered read data.

Function
REQ-012 Storage SHALL be 2^ADDR_LEN words x 32 bits, addressed by word; each port SHALL use only address bits [ADDR_LEN-1:0], upper bits ignored (aliasing wrap-around).
REQ-013 All memory words SHALL power up as 32'h0.
REQ-014 Both ports SHALL be fully independent, each capable of one read and one byte-masked write per cycle.
REQ-015 Read latency SHALL be 1 cycle: douta/doutb at edge N+1 reflect the word at the address presented before edge N+1, and hold until the next edge.
REQ-016 Read-during-write on the same port SHALL be read-first: dout returns the old contents; new data visible on the next read.
REQ-017 A write SHALL update only the bytes whose enable bit is 1; bytes with enable 0 SHALL keep their previous value.
REQ-018 wea=4'b0000 / web=4'b0000 SHALL perform a pure read.
REQ-019 Both ports writing the same word in one cycle: per byte, port B data SHALL win where both enables set; bytes enabled on only one port take that port's data.
REQ-020 Port A reading a word port B writes in the same cycle (or vice versa) SHALL return the old contents.
REQ-021 No byte-lane rotation is performed internally; callers supply data already shifted to the enabled lanes.

Reset
REQ-022 While rst=1 at a rising edge, douta and doutb SHALL be loaded with 32'h0.
REQ-023 While rst=1, all writes on both ports SHALL be suppressed; memory contents SHALL be retained (not cleared).
REQ-024 On the first edge with rst=0 after reset, normal read/write behaviour SHALL resume immediately; a reset asserted mid-operation SHALL only affect the cycle(s) it is high.

Verification
REQ-025 Full-word write/read: port A write 32'hDEADBEEF, wea=4'hF, addra=5; next cycle read addr 5 -> douta=32'hDEADBEEF one cycle later.
REQ-026 Byte mask: word 5=32'hDEADBEEF, write dina=32'h11223344 wea=4'b0101 -> read returns 32'hDE22BE44.
REQ-027 Read-first: word 7=32'hAAAAAAAA; same-cycle write 32'h55555555 to 7 on port A -> douta=32'hAAAAAAAA that cycle, 32'h55555555 on following read.
REQ-028 Dual-port collision: addra=addrb=9, dina=32'h11111111 wea=4'b0011, dinb=32'h22222222 web=4'b0110, prior word 0 -> word 9 = 32'h00222211; port B read of addr 9 via addrb after port A write returns same.
REQ-029 Aliasing: ADDR_LEN=12, write 32'h12345678 to addra=30'h1003 -> read addrb=3 returns 32'h12345678.
REQ-030 Reset: word 4=32'hCAFEF00D, douta nonzero; rst=1 for 2 cycles with wea=4'hF, dina=0, addra=4 -> douta=doutb=0 during reset; after release read addr 4 -> 32'hCAFEF00D.
